// File: rtl/mem_sched.sv
// Byte-serial RAM scheduler: icache refills and load/store buffer
// share one 8-bit RAM/IO port under round-robin arbitration.
module mem_sched #(
  parameter int         LINE_WORDS = 4,
  parameter logic [1:0] IO_SEL     = 2'b11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          flush,
  input  logic                          io_buffer_full,
  input  logic [7:0]                    mem_din,
  output logic [7:0]                    mem_dout,
  output logic [31:0]                   mem_a,
  output logic                          mem_wr,
  input  logic                          ic_req,
  input  logic [31:0]                   ic_addr,
  output logic                          ic_data_valid,
  output logic [$clog2(LINE_WORDS)-1:0] ic_word_idx,
  output logic [31:0]                   ic_data,
  output logic                          ic_done,
  input  logic                          ls_req,
  input  logic                          ls_wr,
  input  logic [1:0]                    ls_width,
  input  logic [31:0]                   ls_addr,
  input  logic [31:0]                   ls_wdata,
  output logic                          ls_done,
  output logic [31:0]                   ls_rdata
);

  localparam int NB = 4 * LINE_WORDS;
  localparam int CW = $clog2(NB + 1);
  localparam int IW = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    IC_RD,
    LS_RD,
    LS_WR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rcv;
  logic [CW-1:0] len;
  logic [31:0]   base;
  logic [31:0]   wdata;
  logic          io_q;
  logic          v1;
  logic          v2;
  logic [31:0]   asm_q;
  logic          last_ic;

  logic          ic_ok;
  logic          ls_ok;
  logic          pick_ic;
  logic          pick_ls;
  logic          can_grant;
  logic          ls_io;
  logic          issue_rd;
  logic          wr_stall;
  logic [CW-1:0] ls_len;
  logic [CW-1:0] rcv_inc;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   cnt_ext;
  logic [31:0]   asm_nxt;
  logic [7:0]    wr_byte;

  // A requester whose done pulse is up still holds req this cycle.
  assign ic_ok     = ic_req && !ic_done;
  assign ls_ok     = ls_req && !ls_done;
  assign pick_ic   = ic_ok && (!ls_ok || !last_ic);
  assign pick_ls   = ls_ok && !pick_ic;
  assign can_grant = rdy && !flush;
  assign ls_io     = ls_addr[17:16] == IO_SEL;
  assign issue_rd  = rdy && (cnt != len);
  assign wr_stall  = io_q && io_buffer_full;
  assign rcv_inc   = rcv + CW'(1);
  assign cnt_inc   = cnt + CW'(1);
  assign cnt_ext   = {{(32-CW){1'b0}}, cnt};
  assign wr_byte   = wdata[{cnt[1:0], 3'b000} +: 8];

  always_comb begin
    ls_len = CW'(4);
    unique case (1'b1)
      ls_width == 2'd0: ls_len = CW'(1);
      ls_width == 2'd1: ls_len = CW'(2);
      default:          ls_len = CW'(4);
    endcase
  end

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{rcv[1:0], 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_a         <= '0;
      mem_dout      <= '0;
      mem_wr        <= 1'b0;
      ic_data_valid <= 1'b0;
      ic_word_idx   <= '0;
      ic_data       <= '0;
      ic_done       <= 1'b0;
      ls_done       <= 1'b0;
      ls_rdata      <= '0;
      cnt           <= '0;
      rcv           <= '0;
      len           <= '0;
      base          <= '0;
      wdata         <= '0;
      io_q          <= 1'b0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      asm_q         <= '0;
      last_ic       <= 1'b0;
    end else begin
      mem_wr        <= 1'b0;
      ic_data_valid <= 1'b0;
      ic_done       <= 1'b0;
      ls_done       <= 1'b0;
      unique case (state)
        IDLE: begin
          v1 <= 1'b0;
          v2 <= 1'b0;
          if (can_grant && (pick_ic || pick_ls)) begin
            mem_a   <= pick_ic ? ic_addr : ls_addr;
            base    <= pick_ic ? ic_addr : ls_addr;
            rcv     <= '0;
            asm_q   <= '0;
            last_ic <= pick_ic;
            if (pick_ic) begin
              state <= IC_RD;
              len   <= CW'(NB);
              cnt   <= CW'(1);
              v1    <= 1'b1;
            end else begin
              len   <= ls_len;
              wdata <= ls_wdata;
              io_q  <= ls_io;
              if (ls_wr) begin
                state <= LS_WR;
                // Byte 0 of a stalled IO store is retried from LS_WR.
                if (ls_io && io_buffer_full) begin
                  cnt <= '0;
                end else begin
                  cnt      <= CW'(1);
                  mem_wr   <= 1'b1;
                  mem_dout <= ls_wdata[7:0];
                end
              end else begin
                state <= LS_RD;
                cnt   <= CW'(1);
                v1    <= 1'b1;
              end
            end
          end
        end
        IC_RD, LS_RD: begin
          if (flush) begin
            state <= IDLE;
            v1    <= 1'b0;
            v2    <= 1'b0;
          end else begin
            v1 <= issue_rd;
            v2 <= v1;
            if (issue_rd) begin
              mem_a <= base + cnt_ext;
              cnt   <= cnt_inc;
            end
            if (v2) begin
              asm_q <= asm_nxt;
              rcv   <= rcv_inc;
              if (state == IC_RD && rcv[1:0] == 2'd3) begin
                ic_data_valid <= 1'b1;
                ic_data       <= asm_nxt;
                ic_word_idx   <= rcv[IW+1:2];
              end
              if (rcv_inc == len) begin
                state <= IDLE;
                v1    <= 1'b0;
                v2    <= 1'b0;
                if (state == IC_RD) begin
                  ic_done <= 1'b1;
                end else begin
                  ls_done  <= 1'b1;
                  ls_rdata <= asm_nxt;
                end
              end
            end
          end
        end
        LS_WR: begin
          if (cnt == len) begin
            state   <= IDLE;
            ls_done <= 1'b1;
          end else if (rdy && !wr_stall) begin
            mem_a    <= base + cnt_ext;
            mem_dout <= wr_byte;
            mem_wr   <= 1'b1;
            cnt      <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sched.sv
// Directed bench for mem_sched with a small synchronous RAM model.
// Outputs are sampled 1ns after each rising edge.
module tb_mem_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_data_valid;
  logic [1:0]  ic_word_idx;
  logic [31:0] ic_data;
  logic        ic_done;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_width;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  logic [7:0]  ram [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_sched #(
    .LINE_WORDS(4),
    .IO_SEL(2'b11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .flush(flush),
    .io_buffer_full(io_buffer_full),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_a(mem_a),
    .mem_wr(mem_wr),
    .ic_req(ic_req),
    .ic_addr(ic_addr),
    .ic_data_valid(ic_data_valid),
    .ic_word_idx(ic_word_idx),
    .ic_data(ic_data),
    .ic_done(ic_done),
    .ls_req(ls_req),
    .ls_wr(ls_wr),
    .ls_width(ls_width),
    .ls_addr(ls_addr),
    .ls_wdata(ls_wdata),
    .ls_done(ls_done),
    .ls_rdata(ls_rdata)
  );

  // RAM: ram[i]=i[7:0], with 11 22 33 44 at 0x100 and A0.. at 0x400.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) begin
        ram[i] <= i[7:0];
      end
      ram[12'h100] <= 8'h11;
      ram[12'h101] <= 8'h22;
      ram[12'h102] <= 8'h33;
      ram[12'h103] <= 8'h44;
      for (int j = 0; j < 16; j++) begin
        ram[12'h400 + j] <= 8'hA0 + 8'(j);
      end
      mem_din <= 8'h00;
    end else begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    rdy            = 1'b1;
    flush          = 1'b0;
    io_buffer_full = 1'b0;
    ic_req         = 1'b0;
    ic_addr        = '0;
    ls_req         = 1'b0;
    ls_wr          = 1'b0;
    ls_width       = 2'd0;
    ls_addr        = '0;
    ls_wdata       = '0;
    tick();
    tick();
    chk("rst_a", mem_a, 32'h0);
    chk("rst_wr", {31'd0, mem_wr}, 32'h0);
    chk("rst_dout", {24'd0, mem_dout}, 32'h0);
    chk("rst_lsd", {31'd0, ls_done}, 32'h0);
    chk("rst_icd", {31'd0, ic_done}, 32'h0);
    chk("rst_icv", {31'd0, ic_data_valid}, 32'h0);
    chk("rst_rdata", ls_rdata, 32'h0);
    chk("rst_icdata", ic_data, 32'h0);
    rst = 1'b0;

    // 4-byte load at 0x100; inputs scrambled after grant
    ls_req = 1'b1; ls_wr = 1'b0; ls_width = 2'd2; ls_addr = 32'h100;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n == 1) begin
        ls_addr  = 32'hDEAD_BEEF;
        ls_width = 2'd0;
      end
      if (n <= 4) chk("ld_a", mem_a, 32'h100 + 32'(n - 1));
      chk("ld_wr", {31'd0, mem_wr}, 32'h0);
      chk("ld_done", {31'd0, ls_done}, {31'd0, n == 6});
    end
    chk("ld_data", ls_rdata, 32'h4433_2211);
    ls_req = 1'b0;
    tick();

    // 2-byte load, zero-extended
    ls_req = 1'b1; ls_width = 2'd1; ls_addr = 32'h102;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("ld2_done", {31'd0, ls_done}, {31'd0, n == 4});
    end
    chk("ld2_data", ls_rdata, 32'h0000_4433);
    ls_req = 1'b0;
    tick();

    // 4-byte load across 32-bit address wrap
    ls_req = 1'b1; ls_width = 2'd2; ls_addr = 32'hFFFF_FFFE;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n <= 4) chk("wrap_a", mem_a, 32'hFFFF_FFFE + 32'(n - 1));
      chk("wrap_done", {31'd0, ls_done}, {31'd0, n == 6});
    end
    chk("wrap_data", ls_rdata, 32'h0100_FFFE);
    ls_req = 1'b0;
    tick();

    // 2-byte store at 0x200
    ls_req = 1'b1; ls_wr = 1'b1; ls_width = 2'd1;
    ls_addr = 32'h200; ls_wdata = 32'hAABB_CCDD;
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk("st_wr", {31'd0, mem_wr}, {31'd0, n <= 2});
      if (n == 1) begin
        chk("st_a0", mem_a, 32'h200);
        chk("st_d0", {24'd0, mem_dout}, 32'hDD);
      end
      if (n == 2) begin
        chk("st_a1", mem_a, 32'h201);
        chk("st_d1", {24'd0, mem_dout}, 32'hCC);
      end
      chk("st_done", {31'd0, ls_done}, {31'd0, n == 3});
    end
    ls_req = 1'b0; ls_wr = 1'b0;
    tick();
    chk("st_ram0", {24'd0, ram[12'h200]}, 32'hDD);
    chk("st_ram1", {24'd0, ram[12'h201]}, 32'hCC);
    chk("st_ram2", {24'd0, ram[12'h202]}, 32'h02);

    // both requesting from reset: icache first, then LSB
    do_reset();
    ic_req = 1'b1; ic_addr = 32'h400;
    ls_req = 1'b1; ls_wr = 1'b0; ls_width = 2'd0; ls_addr = 32'h100;
    for (int n = 1; n <= 21; n++) begin
      logic expv;
      int   w;
      tick();
      expv = (n >= 6) && (n <= 18) && ((n - 6) % 4 == 0);
      w    = (n - 6) / 4;
      chk("rf_v", {31'd0, ic_data_valid}, {31'd0, expv});
      if (expv) begin
        chk("rf_idx", {30'd0, ic_word_idx}, 32'(w));
        chk("rf_data", ic_data, 32'hA3A2_A1A0 + 32'h0404_0404 * 32'(w));
      end
      chk("rf_done", {31'd0, ic_done}, {31'd0, n == 18});
      if (n <= 16) chk("rf_a", mem_a, 32'h400 + 32'(n - 1));
      if (n == 18) ic_req = 1'b0;
      if (n == 19) chk("rr_ls_a", mem_a, 32'h100);
      chk("rr_ls_done", {31'd0, ls_done}, {31'd0, n == 21});
    end
    chk("rr_ls_data", ls_rdata, 32'h11);
    ls_req = 1'b0;
    tick();

    // repeat: icache wins again, flushed after word 1
    ic_req = 1'b1; ls_req = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 1) chk("rr_ic_a", mem_a, 32'h400);
      if (n == 10) begin
        chk("fl_v1", {31'd0, ic_data_valid}, 32'h1);
        chk("fl_d1", ic_data, 32'hA7A6_A5A4);
      end
      if (n >= 11) begin
        chk("fl_nov", {31'd0, ic_data_valid}, 32'h0);
        chk("fl_nod", {31'd0, ic_done}, 32'h0);
      end
      if (n == 12) chk("fl_hold", mem_a, 32'h40A);
      if (n == 13) chk("fl_ls_a", mem_a, 32'h100);
      chk("fl_ls_done", {31'd0, ls_done}, {31'd0, n == 15});
      if (n == 15) begin
        chk("fl_ls_data", ls_rdata, 32'h11);
        ls_req = 1'b0;
      end
      if (n == 16) chk("fl_ic_a", mem_a, 32'h400);
      if (n == 11) flush = 1'b1;
      if (n == 12) flush = 1'b0;
    end
    ic_req = 1'b0;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk("ab_icd", {31'd0, ic_done | ic_data_valid}, 32'h0);
    end

    // IO store stalled by io_buffer_full for 3 cycles
    ls_req = 1'b1; ls_wr = 1'b1; ls_width = 2'd0;
    ls_addr = 32'h0003_0000; ls_wdata = 32'h41;
    io_buffer_full = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("io_wr", {31'd0, mem_wr}, {31'd0, n == 4});
      if (n == 4) begin
        chk("io_a", mem_a, 32'h0003_0000);
        chk("io_d", {24'd0, mem_dout}, 32'h41);
      end
      chk("io_done", {31'd0, ls_done}, {31'd0, n == 5});
      if (n == 3) io_buffer_full = 1'b0;
    end
    ls_req = 1'b0; ls_wr = 1'b0;
    tick();

    // rdy low 2 cycles inside a 4-byte load
    ls_req = 1'b1; ls_width = 2'd2; ls_addr = 32'h100;
    for (int n = 1; n <= 8; n++) begin
      logic [31:0] ea;
      tick();
      ea = (n <= 2) ? 32'h100 + 32'(n - 1) :
           (n <= 4) ? 32'h101 : 32'h100 + 32'(n - 3);
      if (n <= 6) chk("rdy_a", mem_a, ea);
      chk("rdy_done", {31'd0, ls_done}, {31'd0, n == 8});
      if (n == 2) rdy = 1'b0;
      if (n == 4) rdy = 1'b1;
    end
    chk("rdy_data", ls_rdata, 32'h4433_2211);
    ls_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
